// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: E register, condition evaluation, misprediction recovery and predictor update strobe.
// Optional saturating branch/mispredict counters are built when BRU_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | E branch (if any) is evaluated and strobes the predictor update this cycle
// HELD  | E is stalled on a branch that already strobed; suppress further updates
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic [2:0]       Funct3D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic             Predict_branchD,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [XLEN-1:0]  RD1E,
    input  logic [XLEN-1:0]  RD2E,
    output logic             Eval_branch,
    output logic             PCSrcE,
    output logic [XLEN-1:0]  PCTargetE,
    output logic             StateUpdateEnable,
    output logic             MispredictE,
    output logic [XLEN-1:0]  RedirectPCE,
    output logic             FlushD_req,
    output logic             FlushE_req,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredictCount
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    logic            BranchE;
    logic            JumpE;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ImmExtE;
    logic            PredictE;

    logic [0:0] state;
    logic [0:0] stateNext;
    logic       condTaken;

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            BranchE  <= 1'b0;
            JumpE    <= 1'b0;
            Funct3E  <= 3'b000;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            PredictE <= 1'b0;
        end else if (!StallE) begin
            BranchE  <= BranchD;
            JumpE    <= JumpD;
            Funct3E  <= Funct3D;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            ImmExtE  <= ImmExtD;
            PredictE <= Predict_branchD;
        end
    end

    always_comb begin
        condTaken = 1'b0;
        case (Funct3E)
            3'b000:  condTaken = (RD1E == RD2E);
            3'b001:  condTaken = (RD1E != RD2E);
            3'b100:  condTaken = ($signed(RD1E) <  $signed(RD2E));
            3'b101:  condTaken = ($signed(RD1E) >= $signed(RD2E));
            3'b110:  condTaken = (RD1E <  RD2E);
            3'b111:  condTaken = (RD1E >= RD2E);
            default: condTaken = 1'b0;
        endcase
    end

    assign Eval_branch = BranchE | JumpE;
    assign PCSrcE      = JumpE | (BranchE & condTaken);
    assign PCTargetE   = PCE + ImmExtE;
    assign RedirectPCE = PCSrcE ? PCTargetE : PCPlus4E;
    assign MispredictE = Eval_branch & (PCSrcE != PredictE);
    assign FlushD_req  = MispredictE;
    assign FlushE_req  = MispredictE;

    // A cycle with rst asserted never trains the predictor, even from IDLE.
    assign StateUpdateEnable = (state == IDLE) & Eval_branch & ~rst;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (Eval_branch && StallE && !FlushE) stateNext = HELD;
            HELD:    if (!StallE || FlushE) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] branchCnt;
    logic [CNT_W-1:0] mispredictCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            branchCnt     <= '0;
            mispredictCnt <= '0;
        end else if (StateUpdateEnable) begin
            if (branchCnt != '1) branchCnt <= branchCnt + CNT_W'(1);
            if (MispredictE && (mispredictCnt != '1)) mispredictCnt <= mispredictCnt + CNT_W'(1);
        end
    end

    assign BranchCount     = branchCnt;
    assign MispredictCount = mispredictCnt;
`else
    assign BranchCount     = '0;
    assign MispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model predicts each cycle's outputs,
// pushes them to a queue, and the entry is popped and compared at the following negedge.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             BranchD, JumpD, Predict_branchD, StallE, FlushE;
    logic [2:0]       Funct3D;
    logic [XLEN-1:0]  PCD, PCPlus4D, ImmExtD, RD1E, RD2E;
    logic             Eval_branch, PCSrcE, StateUpdateEnable, MispredictE, FlushD_req, FlushE_req;
    logic [XLEN-1:0]  PCTargetE, RedirectPCE;
    logic [CNT_W-1:0] BranchCount, MispredictCount;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .BranchD(BranchD), .JumpD(JumpD), .Funct3D(Funct3D),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Predict_branchD(Predict_branchD), .StallE(StallE), .FlushE(FlushE),
        .RD1E(RD1E), .RD2E(RD2E),
        .Eval_branch(Eval_branch), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StateUpdateEnable(StateUpdateEnable), .MispredictE(MispredictE),
        .RedirectPCE(RedirectPCE), .FlushD_req(FlushD_req), .FlushE_req(FlushE_req),
        .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    typedef struct packed {
        logic            eval;
        logic            pcsrc;
        logic            sue;
        logic            mis;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] redirect;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] mc;
    } exp_t;

    exp_t sbQ[$];
    int   nChecks = 0;
    int   nErrors = 0;

    // Reference model state
    logic            mB, mJ, mPred, mHeld;
    logic [2:0]      mF3;
    logic [XLEN-1:0] mPC, mP4, mImm;
    int              mBC, mMC;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nErrors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic taken(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic setD(input logic br, input logic jp, input logic [2:0] f3,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic pred);
        BranchD = br; JumpD = jp; Funct3D = f3; PCD = pc; PCPlus4D = pc + 4;
        ImmExtD = imm; Predict_branchD = pred;
    endtask

    task automatic tick();
        exp_t e;
        exp_t got;
        e.eval     = mB | mJ;
        e.pcsrc    = mJ | (mB & taken(mF3, RD1E, RD2E));
        e.mis      = e.eval & (e.pcsrc != mPred);
        e.target   = mPC + mImm;
        e.redirect = e.pcsrc ? e.target : mP4;
        e.sue      = !mHeld & e.eval & !rst;
`ifdef BRU_PERF_CNT_EN
        e.bc = CNT_W'(mBC);
        e.mc = CNT_W'(mMC);
`else
        e.bc = '0;
        e.mc = '0;
`endif
        sbQ.push_back(e);
        @(negedge clk);
        got = sbQ.pop_front();
        chk("Eval_branch", 64'(Eval_branch), 64'(got.eval));
        chk("PCSrcE", 64'(PCSrcE), 64'(got.pcsrc));
        chk("PCTargetE", 64'(PCTargetE), 64'(got.target));
        chk("RedirectPCE", 64'(RedirectPCE), 64'(got.redirect));
        chk("MispredictE", 64'(MispredictE), 64'(got.mis));
        chk("FlushD_req", 64'(FlushD_req), 64'(got.mis));
        chk("FlushE_req", 64'(FlushE_req), 64'(got.mis));
        chk("StateUpdateEnable", 64'(StateUpdateEnable), 64'(got.sue));
        chk("BranchCount", 64'(BranchCount), 64'(got.bc));
        chk("MispredictCount", 64'(MispredictCount), 64'(got.mc));
        @(posedge clk);
        if (rst) begin
            {mB, mJ, mPred, mHeld} = '0;
            mF3 = '0; mPC = '0; mP4 = '0; mImm = '0;
            mBC = 0; mMC = 0;
        end else begin
            if (e.sue) begin
                if (mBC < CMAX) mBC++;
                if (e.mis && mMC < CMAX) mMC++;
            end
            if (!mHeld) mHeld = e.eval & StallE & !FlushE;
            else        mHeld = StallE & !FlushE;
            if (FlushE) begin
                {mB, mJ, mPred} = '0;
                mF3 = '0; mPC = '0; mP4 = '0; mImm = '0;
            end else if (!StallE) begin
                mB = BranchD; mJ = JumpD; mF3 = Funct3D; mPC = PCD;
                mP4 = PCPlus4D; mImm = ImmExtD; mPred = Predict_branchD;
            end
        end
        #1;
    endtask

    initial begin
        {mB, mJ, mPred, mHeld} = '0;
        mF3 = '0; mPC = '0; mP4 = '0; mImm = '0;
        mBC = 0; mMC = 0;
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        RD1E = '0; RD2E = '0;
        setD(0, 0, 0, '0, '0, 0);
        PCPlus4D = '0;
        tick(); tick();
        rst = 1'b0;

        // BEQ taken, predicted taken
        setD(1, 0, 3'd0, 32'h40, 32'h10, 1); tick();
        setD(0, 0, 0, 0, 0, 0); RD1E = 5; RD2E = 5; tick();
        // BLT taken, predicted not taken
        setD(1, 0, 3'd4, 32'h100, 32'h20, 0); tick();
        setD(0, 0, 0, 0, 0, 0); RD1E = 32'hFFFF_FFFF; RD2E = 1; tick();
        // BLTU not taken, predicted taken
        setD(1, 0, 3'd6, 32'h200, 32'h30, 1); tick();
        setD(0, 0, 0, 0, 0, 0); tick();
        // JAL predicted not taken, then BNE/BGE/BGEU/reserved back-to-back
        setD(0, 1, 3'd0, 32'h300, 32'hFFFF_FFF0, 0); tick();
        setD(1, 0, 3'd1, 32'h310, 32'h8, 1); tick();
        setD(1, 0, 3'd5, 32'h320, 32'h8, 0); RD1E = 32'h8000_0000; RD2E = 3; tick();
        setD(1, 0, 3'd7, 32'h330, 32'h8, 1); tick();
        setD(1, 0, 3'd2, 32'h340, 32'h8, 1); tick();
        setD(0, 0, 0, 0, 0, 0); tick();

        // Stall a branch for three cycles, then release onto a new branch
        setD(1, 0, 3'd0, 32'h400, 32'h40, 0); RD1E = 7; RD2E = 7; tick();
        StallE = 1'b1; setD(1, 0, 3'd1, 32'h500, 32'h4, 1);
        tick(); tick(); tick();
        StallE = 1'b0; tick();
        setD(0, 0, 0, 0, 0, 0); tick(); tick();

        // FlushE together with StallE while a branch sits in E
        setD(1, 0, 3'd0, 32'h600, 32'h8, 1); tick();
        StallE = 1'b1; FlushE = 1'b1; tick();
        StallE = 1'b0; FlushE = 1'b0; tick();

        // Reset while HELD
        setD(1, 0, 3'd4, 32'h700, 32'h8, 1); RD1E = 1; RD2E = 2; tick();
        StallE = 1'b1; tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0; StallE = 1'b0; setD(0, 0, 0, 0, 0, 0); tick(); tick();

        // Back-to-back branches past counter saturation
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            setD(1, 0, 3'd0, 32'h1000 + 32'(i * 4), 32'h20, 1'($urandom_range(0, 1)));
            RD1E = 32'($urandom_range(0, 1)); RD2E = 0;
            tick();
        end
        setD(0, 0, 0, 0, 0, 0); tick(); tick();

        // Random traffic with occasional stall/flush
        for (int i = 0; i < 60; i++) begin
            setD(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, 1'($urandom_range(0, 1)));
            RD1E = ($urandom_range(0, 2) == 0) ? RD2E : $urandom;
            RD2E = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
            StallE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            tick();
        end
        StallE = 1'b0; FlushE = 1'b0;
        tick();

        if (sbQ.size() != 0) chk("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
